// File: rtl/pong_engine.sv
// pong_engine: single-clock pong core, quadrature paddles, pixel video.
// Define PONG_AI_EN to let the right paddle follow the ball on its own.
module pong_engine #(
  parameter int XW           = 10,
  parameter int YW           = 10,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL         = 16,
  parameter int PADDLE_LEN   = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_XL    = 16,
  parameter int PADDLE_XR    = 616,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XW-1:0]      pix_x,
  input  logic [YW-1:0]      pix_y,
  input  logic               pix_valid,
  input  logic               frame_tick,
  input  logic               quadA_l,
  input  logic               quadB_l,
  input  logic               quadA_r,
  input  logic               quadB_r,
  output logic               vga_R,
  output logic               vga_G,
  output logic               vga_B,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    POINT = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int BX0  = (H_ACTIVE - BALL) / 2;
  localparam int BY0  = (V_ACTIVE - BALL) / 2;
  localparam int PY0  = (V_ACTIVE - PADDLE_LEN) / 2;
  localparam int PMAX = V_ACTIVE - PADDLE_LEN;
  localparam int XMAX = H_ACTIVE - BALL;
  localparam int YMAX = V_ACTIVE - BALL;
  localparam int LHIT = PADDLE_XL + PADDLE_W;
  localparam int RHIT = PADDLE_XR - BALL;
  localparam int CW   = $clog2(SERVE_FRAMES + 1);
  localparam logic [SCORE_W-1:0] SMAX = '1;

  state_t             st;
  logic [CW-1:0]      cnt;
  logic [XW-1:0]      ballX;
  logic [YW-1:0]      ballY;
  logic [YW-1:0]      padL;
  logic [YW-1:0]      padR;
  logic               dirX;
  logic               dirY;
  logic [SCORE_W-1:0] scoreL;
  logic [SCORE_W-1:0] scoreR;
  logic               pixOn;

  function automatic logic [YW-1:0] padMove(
    input logic [YW-1:0] p,
    input logic          s,
    input logic          up
  );
    padMove = p;
    if (s && up && int'(p) < PMAX)
      padMove = p + 1'b1;
    else if (s && !up && p != '0)
      padMove = p - 1'b1;
  endfunction

  logic [2:0] aL, bL;
  logic       stepL, upL;

  assign stepL = (aL[2] ^ aL[1]) | (bL[2] ^ bL[1]);
  assign upL   = aL[2] ^ bL[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aL   <= '0;
      bL   <= '0;
      padL <= YW'(PY0);
    end else begin
      aL   <= {aL[1:0], quadA_l};
      bL   <= {bL[1:0], quadB_l};
      padL <= padMove(padL, stepL, upL);
    end
  end

`ifdef PONG_AI_EN
  int padC, ballC;

  assign padC  = int'(padR) + PADDLE_LEN / 2;
  assign ballC = int'(ballY) + BALL / 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      padR <= YW'(PY0);
    else if (frame_tick) begin
      if (padC < ballC)
        padR <= padMove(padR, 1'b1, 1'b1);
      else if (padC > ballC)
        padR <= padMove(padR, 1'b1, 1'b0);
    end
  end
`else
  logic [2:0] aR, bR;
  logic       stepR, upR;

  assign stepR = (aR[2] ^ aR[1]) | (bR[2] ^ bR[1]);
  assign upR   = aR[2] ^ bR[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aR   <= '0;
      bR   <= '0;
      padR <= YW'(PY0);
    end else begin
      aR   <= {aR[1:0], quadA_r};
      bR   <= {bR[1:0], quadB_r};
      padR <= padMove(padR, stepR, upR);
    end
  end
`endif

  int   nx, ny;
  logic ovlL, ovlR;
  logic hitL, hitR;
  logic missL, missR;

  always_comb begin
    nx = dirX ? int'(ballX) - SPEED
              : int'(ballX) + SPEED;
    ny = dirY ? int'(ballY) - SPEED
              : int'(ballY) + SPEED;
    ovlL = int'(ballY) < int'(padL) + PADDLE_LEN
        && int'(padL) < int'(ballY) + BALL;
    ovlR = int'(ballY) < int'(padR) + PADDLE_LEN
        && int'(padR) < int'(ballY) + BALL;
    hitL = dirX && nx <= LHIT
        && int'(ballX) >= LHIT && ovlL;
    hitR = !dirX && nx >= RHIT
        && int'(ballX) <= RHIT && ovlR;
    missL = !hitL && nx < 0;
    missR = !hitR && nx > XMAX;
  end

  // dirX already points at whoever missed, so it doubles as the serve side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= SERVE;
      cnt    <= '0;
      ballX  <= XW'(BX0);
      ballY  <= YW'(BY0);
      dirX   <= 1'b0;
      dirY   <= 1'b0;
      scoreL <= '0;
      scoreR <= '0;
    end else if (frame_tick) begin
      unique case (st)
        SERVE: begin
          if (int'(cnt) == SERVE_FRAMES - 1) begin
            st  <= PLAY;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PLAY: begin
          if (missL || missR) begin
            st <= POINT;
            if (missL && scoreR != SMAX)
              scoreR <= scoreR + 1'b1;
            if (missR && scoreL != SMAX)
              scoreL <= scoreL + 1'b1;
          end else begin
            if (hitL) begin
              ballX <= XW'(LHIT);
              dirX  <= 1'b0;
            end else if (hitR) begin
              ballX <= XW'(RHIT);
              dirX  <= 1'b1;
            end else begin
              ballX <= XW'(nx);
            end
            if (ny < 0) begin
              ballY <= '0;
              dirY  <= 1'b0;
            end else if (ny > YMAX) begin
              ballY <= YW'(YMAX);
              dirY  <= 1'b1;
            end else begin
              ballY <= YW'(ny);
            end
          end
        end
        POINT: begin
          if (scoreL == SMAX || scoreR == SMAX) begin
            st <= OVER;
          end else begin
            st    <= SERVE;
            ballX <= XW'(BX0);
            ballY <= YW'(BY0);
          end
        end
        OVER: st <= OVER;
      endcase
    end
  end

  int   px, py, bx, by, pl, pr;
  logic onBall, onPadL, onPadR, onCtr;

  always_comb begin
    px = int'(pix_x);
    py = int'(pix_y);
    bx = int'(ballX);
    by = int'(ballY);
    pl = int'(padL);
    pr = int'(padR);
    onBall = px >= bx && px < bx + BALL
          && py >= by && py < by + BALL;
    onPadL = px >= PADDLE_XL
          && px < PADDLE_XL + PADDLE_W
          && py >= pl && py < pl + PADDLE_LEN;
    onPadR = px >= PADDLE_XR
          && px < PADDLE_XR + PADDLE_W
          && py >= pr && py < pr + PADDLE_LEN;
    onCtr = px >= H_ACTIVE / 2 - 1
         && px <= H_ACTIVE / 2 && !pix_y[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pixOn <= 1'b0;
    else
      pixOn <= pix_valid
             & (onBall | onPadL | onPadR | onCtr);
  end

  assign vga_R   = pixOn;
  assign vga_G   = pixOn;
  assign vga_B   = pixOn;
  assign score_l = scoreL;
  assign score_r = scoreR;
  assign state   = st;

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: randomized paddle play against a rule-level game model.
// Video is probed pixel by pixel and compared with the model's picture.
module tb_pong_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       pix_valid = 1'b0;
  logic       frame_tick = 1'b0;
  logic       quadA_l = 1'b0;
  logic       quadB_l = 1'b0;
  logic       quadA_r = 1'b0;
  logic       quadB_r = 1'b0;
  logic       vga_R, vga_G, vga_B;
  logic [3:0] score_l, score_r;
  logic [1:0] state;

  pong_engine dut (
    .clk(clk), .rst_n(rst_n),
    .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .frame_tick(frame_tick),
    .quadA_l(quadA_l), .quadB_l(quadB_l),
    .quadA_r(quadA_r), .quadB_r(quadB_r),
    .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
    .score_l(score_l), .score_r(score_r),
    .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // rule-level game model
  int mBx, mBy, mDx, mDy, mPl, mPr;
  int mSl, mSr, mSt, mCnt, loser;
  int hitsL = 0;
  int hitsR = 0;
  int phL = 0;
  int phR = 0;
  logic [1:0] gray [4];

  function automatic int clampPad(input int p);
    return p < 0 ? 0 : (p > 416 ? 416 : p);
  endfunction

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  task automatic mReset();
    mBx = 312; mBy = 232; mDx = 0; mDy = 0;
    mPl = 208; mPr = 208;
    mSl = 0; mSr = 0; mSt = 0; mCnt = 0;
  endtask

  task automatic mTick();
    int nx, ny;
    bit ovl, ovr, hl, hr;
    case (mSt)
      0: begin
        mCnt++;
        if (mCnt == 60) begin
          mSt = 1;
          mCnt = 0;
        end
      end
      1: begin
        nx = mBx + (mDx ? -2 : 2);
        ny = mBy + (mDy ? -2 : 2);
        ovl = mBy < mPl + 64 && mPl < mBy + 16;
        ovr = mBy < mPr + 64 && mPr < mBy + 16;
        hl = mDx == 1 && nx <= 24 && mBx >= 24 && ovl;
        hr = mDx == 0 && nx >= 600 && mBx <= 600 && ovr;
        if (!hl && nx < 0) begin
          if (mSr < 15) mSr++;
          mSt = 2;
          loser = 0;
        end else if (!hr && nx > 624) begin
          if (mSl < 15) mSl++;
          mSt = 2;
          loser = 1;
        end else begin
          if (hl) begin
            mBx = 24; mDx = 0; hitsL++;
          end else if (hr) begin
            mBx = 600; mDx = 1; hitsR++;
          end else begin
            mBx = nx;
          end
          if (ny < 0) begin
            mBy = 0; mDy = 0;
          end else if (ny > 464) begin
            mBy = 464; mDy = 1;
          end else begin
            mBy = ny;
          end
        end
      end
      2: begin
        if (mSl == 15 || mSr == 15) begin
          mSt = 3;
        end else begin
          mSt = 0;
          mBx = 312;
          mBy = 232;
          mDx = (loser == 0) ? 1 : 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic bit mOn(input int x, input int y);
    bit b, l, r, c;
    b = x >= mBx && x < mBx + 16 && y >= mBy && y < mBy + 16;
    l = x >= 16 && x < 24 && y >= mPl && y < mPl + 64;
    r = x >= 616 && x < 624 && y >= mPr && y < mPr + 64;
    c = (x == 319 || x == 320) && y >= 0 && ((y / 8) % 2 == 0);
    return b | l | r | c;
  endfunction

  task automatic probe(input int x, input int y, input bit v);
    bit e;
    @(negedge clk);
    pix_x = 10'(x);
    pix_y = 10'(y);
    pix_valid = v;
    e = v && x >= 0 && y >= 0 && mOn(x, y);
    @(negedge clk);
    chk($sformatf("pix(%0d,%0d,v%0d)", x, y, v),
        {vga_R, vga_G, vga_B}, e ? 7 : 0);
  endtask

  task automatic padProbe();
    probe(16, mPl, 1);
    probe(23, mPl + 63, 1);
    probe(16, mPl - 1, 1);
    probe(16, mPl + 64, 1);
    probe(616, mPr, 1);
    probe(623, mPr + 63, 1);
    probe(616, mPr - 1, 1);
    probe(616, mPr + 64, 1);
  endtask

  task automatic ballProbe();
    probe(mBx, mBy, 1);
    probe(mBx + 15, mBy + 15, 1);
    probe(mBx - 1, mBy + 7, 1);
    probe(mBx + 16, mBy + 7, 1);
  endtask

  // positive count = Y grows (B leads A), negative = Y shrinks
  task automatic quadSteps(input int nl, input int nr);
    int n;
    n = iabs(nl) > iabs(nr) ? iabs(nl) : iabs(nr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (nl > 0 && i < nl) begin
        phL = (phL + 1) % 4; mPl = clampPad(mPl + 1);
      end else if (nl < 0 && i < -nl) begin
        phL = (phL + 3) % 4; mPl = clampPad(mPl - 1);
      end
      if (nr > 0 && i < nr) begin
        phR = (phR + 1) % 4; mPr = clampPad(mPr + 1);
      end else if (nr < 0 && i < -nr) begin
        phR = (phR + 3) % 4; mPr = clampPad(mPr - 1);
      end
      {quadA_l, quadB_l} = gray[phL];
      {quadA_r, quadB_r} = gray[phR];
    end
    if (n > 0) repeat (3) @(negedge clk);
  endtask

  task automatic frameTick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    mTick();
    chk("state", int'(state), mSt);
    chk("score_l", int'(score_l), mSl);
    chk("score_r", int'(score_r), mSr);
  endtask

  function automatic int steer(input int pad, input int by,
                               input bit follow);
    int tgt, d, lim;
    if (follow) tgt = clampPad(by + 8 - 32);
    else tgt = (by + 8 < 240) ? 416 : 0;
    d = tgt - pad;
    lim = follow ? int'($urandom_range(4, 2))
                 : int'($urandom_range(5, 3));
    if (d > lim) d = lim;
    else if (d < -lim) d = -lim;
    return d;
  endfunction

  initial begin
    int frames;
    bit folL, folR;
    gray = '{2'b00, 2'b01, 2'b11, 2'b10};
    mReset();

    pix_x = 10'd320; pix_y = 10'd0; pix_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_vga", {vga_R, vga_G, vga_B}, 0);
    chk("rst_state", int'(state), 0);
    chk("rst_score_l", int'(score_l), 0);
    chk("rst_score_r", int'(score_r), 0);
    rst_n = 1'b1;

    ballProbe();
    padProbe();
    probe(320, 0, 1);
    probe(320, 0, 0);
    probe(319, 8, 1);
    probe(321, 0, 1);

    quadSteps(-250, 0);
    quadSteps(-5, 0);
    probe(16, 0, 1);
    probe(16, 64, 1);
    quadSteps(500, 0);
    probe(16, 415, 1);
    probe(16, 416, 1);
    probe(16, 479, 1);

    frames = 0;
    while (mSt != 3 && frames < 6000) begin
      folL = !(hitsR >= 1 && mSr == 0);
      folR = (hitsR == 0);
      quadSteps(steer(mPl, mBy, folL), steer(mPr, mBy, folR));
      frameTick();
      ballProbe();
      probe($urandom_range(639, 0), $urandom_range(479, 0),
            1'($urandom_range(1, 0)));
      if (frames % 16 == 0) padProbe();
      frames++;
    end
    chk("reach_over", int'(state), 3);

    for (int i = 0; i < 10; i++) begin
      quadSteps($urandom_range(6, 0) - 3, $urandom_range(6, 0) - 3);
      frameTick();
      ballProbe();
      padProbe();
    end

    probe(320, 0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    {quadA_l, quadB_l, quadA_r, quadB_r} = 4'b0000;
    phL = 0;
    phR = 0;
    #1;
    chk("mid_rst_vga", {vga_R, vga_G, vga_B}, 0);
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_score_l", int'(score_l), 0);
    chk("mid_rst_score_r", int'(score_r), 0);
    mReset();
    @(negedge clk);
    rst_n = 1'b1;
    frameTick();
    ballProbe();
    padProbe();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_engine.md
PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 Parameters: XW, 10, pixel X coordinate width.
REQ-002 YW, 10, pixel Y coordinate width.
REQ-003 H_ACTIVE, 640 and V_ACTIVE, 480, playfield size in pixels.
REQ-004 BALL, 16, ball edge length (square).
REQ-005 PADDLE_LEN, 64 and PADDLE_W, 8, paddle height and width.
REQ-006 PADDLE_XL, 16 and PADDLE_XR, 616, left X edge of the left and right paddles.
REQ-007 SPEED, 2, ball pixels per axis per frame.
REQ-008 SERVE_FRAMES, 60, frames the ball rests before a serve.
REQ-009 SCORE_W, 4, score counter width.
REQ-010 Ports: clk  in  1  system/pixel clock; single clock domain.
REQ-011 rst_n  in  1  asynchronous reset, active-low.
REQ-012 pix_x  in  XW  and  pix_y  in  YW  current pixel coordinate from the sync generator.
REQ-013 pix_valid  in  1  high inside the display area.
REQ-014 frame_tick  in  1  one-cycle pulse once per frame, during vertical blanking.
REQ-015 quadA_l, quadB_l, quadA_r, quadB_r  in  1 each  asynchronous quadrature encoder inputs for the left and right players.
REQ-016 vga_R, vga_G, vga_B  out  1 each  registered colour outputs.
REQ-017 score_l, score_r  out  SCORE_W each  player scores.
REQ-018 state  out  2  FSM state: SERVE=0, PLAY=1, POINT=2, OVER=3.

Function
REQ-019 Each quadrature pair SHALL pass through a 3-flop synchroniser; a step is detected on any A/B edge; direction is (A[2]^B[1]); paddle Y moves by 1 pixel per step.
REQ-020 Paddle Y (top edge) SHALL saturate in 0..V_ACTIVE-PADDLE_LEN; no wrap-around.
REQ-021 Ball state (ball_x, ball_y, dir_x, dir_y) SHALL update only on frame_tick; otherwise it holds.
REQ-022 SERVE: ball at ((H_ACTIVE-BALL)/2, (V_ACTIVE-BALL)/2), stationary; frame counter counts frame_ticks; on the SERVE_FRAMES-th tick go to PLAY.
REQ-023 PLAY: each frame_tick moves the ball SPEED on each axis in the dir_x/dir_y direction (0 = +, 1 = -).
REQ-024 Wall: if the next Y would be <0, set Y=0 and dir_y=0; if it would be >V_ACTIVE-BALL, set it to V_ACTIVE-BALL and dir_y=1.
REQ-025 Paddle hit: moving left, next X <= PADDLE_XL+PADDLE_W, current X >= PADDLE_XL+PADDLE_W, and Y ranges overlap -> X=PADDLE_XL+PADDLE_W, dir_x=0. The right paddle uses the mirror rule with X=PADDLE_XR-BALL, dir_x=1.
REQ-026 Miss: next X <0 -> score_r+1; next X >H_ACTIVE-BALL -> score_l+1; the ball freezes and the FSM goes to POINT.
REQ-027 A wall and a paddle reflection in the same frame SHALL both apply, independently per axis.
REQ-028 POINT lasts exactly one frame_tick. If a score has reached 2^SCORE_W-1, go to OVER; otherwise go to SERVE with dir_x pointing toward the player who conceded.
REQ-029 OVER SHALL hold the ball and both scores until reset; paddles stay live.
REQ-030 Scores SHALL saturate and never wrap.
REQ-031 Video: on = ball | paddle_l | paddle_r | centre line (pix_x in H_ACTIVE/2-1..H_ACTIVE/2 and pix_y[3]==0). vga_R/G/B = on & pix_valid, registered with 1-cycle latency from pix_x/pix_y.
REQ-032 A quad step and a frame_tick in the same cycle SHALL both take effect; collision tests use the pre-step paddle position.

Reset
REQ-033 rst_n low SHALL asynchronously force: vga_R/G/B=0, scores=0, state=SERVE, serve counter=0, ball centred, dir_x=0, dir_y=0, both paddles at (V_ACTIVE-PADDLE_LEN)/2, synchronisers=0.
REQ-034 Reset asserted mid-line or mid-frame SHALL blank the outputs in the same cycle; operation resumes at the first frame_tick after release.

Configuration
REQ-035 PONG_AI_EN defined: the right paddle SHALL ignore quadA_r/quadB_r; on each frame_tick it moves 1 pixel toward alignment of its centre with the ball centre, with the same saturation; it does not move when the two are aligned.
REQ-036 PONG_AI_EN undefined: the right paddle is driven by its quadrature encoder exactly as the left one.

Verification
REQ-037 Reset, then 60 frame_ticks -> state SERVE until the 60th tick, then PLAY; ball at (312,232) before the 60th tick.
REQ-038 Left paddle at 0, 5 down-steps on quadA_l/B_l -> paddle Y=0 (saturated); 500 up-steps -> 416.
REQ-039 Ball X=26, dir_x=1, left paddle overlapping, frame_tick -> X=24, dir_x=0, scores unchanged.
REQ-040 Ball X=1, dir_x=1, no overlap, frame_tick -> score_r=1, state POINT; next tick -> SERVE with dir_x=1.
REQ-041 score_l=14, right miss -> score_l=15, POINT, then OVER; further ticks leave the ball and scores unchanged.
REQ-042 Pixel (320,0) with pix_valid=1 -> vga_R/G/B=1 one cycle later; same pixel with pix_valid=0 -> 0.
